// File: rtl/tpu_pkg.sv
// Shared TPU constants and the row/lane slicing helper used by the systolic
// array, the input FIFOs and the weight skew FIFO.
package tpu_pkg;

    localparam int unsigned TPU_DATA_WIDTH = 8;
    localparam int unsigned TPU_NUM_COLS   = 4;

    // Widest row/lane the helper can slice; callers size-cast in and out.
    localparam int unsigned TPU_MAX_ROW_W  = 1024;
    localparam int unsigned TPU_MAX_LANE_W = 64;

    typedef logic [TPU_MAX_ROW_W-1:0]  tpu_row_t;
    typedef logic [TPU_MAX_LANE_W-1:0] tpu_lane_t;

    // Lane c of a packed row, lane c = bits [w*(c+1)-1 : w*c].
    function automatic tpu_lane_t get_lane(input tpu_row_t    row,
                                           input int unsigned c,
                                           input int unsigned w = TPU_DATA_WIDTH);
        tpu_row_t  sh;
        tpu_lane_t mask;
        sh   = row >> (c * w);
        mask = (w >= TPU_MAX_LANE_W) ? '1 : ((tpu_lane_t'(1) << w) - tpu_lane_t'(1));
        return sh[TPU_MAX_LANE_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/weight_skew_delay.sv
// Fixed-length {valid, data} delay line for one lane of the weight skew stage.
module weight_skew_delay #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  d_valid,
    input  logic [DATA_WIDTH-1:0] d_data,
    output logic                  q_valid,
    output logic [DATA_WIDTH-1:0] q_data
);

    logic [DATA_WIDTH:0] pipe [STAGES];

    // Shift every cycle; reset and clear drop anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < STAGES; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= {d_valid, d_data};
            for (int unsigned i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q_valid = pipe[STAGES-1][DATA_WIDTH];
    assign q_data  = pipe[STAGES-1][DATA_WIDTH-1:0];

endmodule

// File: rtl/weight_skew_fifo.sv
// Weight row FIFO for the top edge of the systolic array: circular buffer with
// FWFT output, recirculating replay and a diagonal per-lane skew stage.
module weight_skew_fifo
    import tpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = TPU_DATA_WIDTH,
    parameter int unsigned NUM_COLS   = TPU_NUM_COLS,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic                               recirc,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH*NUM_COLS-1:0]     in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH*NUM_COLS-1:0]     out_data,
    output logic [DATA_WIDTH*NUM_COLS-1:0]     skew_data,
    output logic [NUM_COLS-1:0]                skew_valid,
    output logic [$clog2(DEPTH):0]             count,
    output logic                               full,
    output logic                               empty
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned ROW_W  = DATA_WIDTH * NUM_COLS;

    logic [ROW_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic [ROW_W-1:0]  wr_data;

    assign empty     = (count == '0);
    assign full      = (count == (ADDR_W+1)'(DEPTH));
    assign in_ready  = ~full & ~recirc;
    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Recirculation reuses the write port: the popped head goes back to the tail.
    assign wr_en   = ~clear & (push | (recirc & pop));
    assign wr_data = recirc ? out_data : in_data;

    // Row storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy update; clear has priority over all traffic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Lane c is delayed c+1 cycles so popped rows enter the array diagonally.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_in;
        logic [DATA_WIDTH-1:0] lane_q;
        logic                  lane_v;

        assign lane_in = pop ? DATA_WIDTH'(get_lane(tpu_row_t'(out_data), c, DATA_WIDTH)) : '0;

        weight_skew_delay #(
            .DATA_WIDTH (DATA_WIDTH),
            .STAGES     (c + 1)
        ) u_delay (
            .clk     (clk),
            .reset   (reset),
            .clear   (clear),
            .d_valid (pop),
            .d_data  (lane_in),
            .q_valid (lane_v),
            .q_data  (lane_q)
        );

        assign skew_data[DATA_WIDTH*c +: DATA_WIDTH] = lane_q;
        assign skew_valid[c]                         = lane_v;
    end

endmodule

// File: doc/weight_skew_fifo.md
Name: weight_skew_fifo

Overview:
- Parametrised successor to the weight shift-FIFO, feeding weight rows into the top of the systolic array.
- Circular buffer of DEPTH rows, each NUM_COLS lanes of DATA_WIDTH bits.
- Valid/ready on both sides, first-word fall-through, occupancy flags and a recirculate mode so a weight tile can be replayed without reloading.
- A built-in per-lane skew stage staggers popped rows diagonally (lane c delayed c+1 cycles) for direct systolic injection.

Parameters:
- DATA_WIDTH, 8, bits per weight lane.
- NUM_COLS, 4, lanes per row (array width).
- DEPTH, 4, rows stored. Must be a power of 2 and at least 2.
- ADDR_W, $clog2(DEPTH), derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous flush of buffer and skew stage.
- recirc  in  1  replay mode: each popped row is rewritten at the tail.
- in_valid  in  1  producer has a row.
- in_ready  out  1  FIFO accepts a row.
- in_data  in  DATA_WIDTH*NUM_COLS  row; lane c = bits [DATA_WIDTH*(c+1)-1 : DATA_WIDTH*c].
- out_valid  out  1  head row available.
- out_ready  in  1  consumer takes the head row.
- out_data  out  DATA_WIDTH*NUM_COLS  head row (FWFT).
- skew_data  out  DATA_WIDTH*NUM_COLS  diagonally staggered popped rows.
- skew_valid  out  NUM_COLS  per-lane valid for skew_data.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (async assert, sync release): rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0, out_valid = 0, out_data = 0, skew_data = 0, skew_valid = 0. Storage array is not reset.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = !full & !recirc (registered-flag based, no combinational path from out_ready).
- out_valid = !empty. out_data = mem[rd_ptr] when !empty, else all zeros.
- Push only: mem[wr_ptr] <= in_data, wr_ptr++, count++.
- Pop only: rd_ptr++, count--.
- Push and pop in the same cycle (0 < count < DEPTH): both pointers advance, count unchanged.
- Recirc and pop: mem[wr_ptr] <= out_data, both pointers advance, count unchanged.
- Recirc with no pop: nothing changes. External pushes are blocked (in_ready = 0).
- Pointers wrap DEPTH-1 -> 0 by natural ADDR_W overflow.
- Pop when empty is impossible (out_valid = 0). Push when full is impossible (in_ready = 0).
- clear: next edge, pointers and count go to 0 and the skew pipe to zero/invalid. clear overrides push, pop and recirc in that cycle.
- Skew stage:
  - Lane c is a (c+1)-deep register chain advancing every cycle, unconditionally.
  - Input to the chain is {out_data lane c, pop} when pop, else {0, 0}.
  - If a pop occurs at edge T, lane c appears on skew_data / skew_valid[c] after edge T+c.
  - Lane 0 therefore lags the pop by one cycle; lane NUM_COLS-1 lags it by NUM_COLS cycles.
- Mid-operation reset or clear: any row partially through the skew pipe is dropped; no lane keeps a stale valid.

Decomposition:
- Shared package tpu_pkg: default DATA_WIDTH and NUM_COLS constants, plus a row-slice helper function get_lane(row, c). The same package is used by the systolic array and the input FIFOs.
- One sub-module: weight_skew_delay (parameters DATA_WIDTH, STAGES). It is a DATA_WIDTH+1-bit register chain with async reset, instantiated NUM_COLS times via generate with STAGES = c+1.

Test Plan:
- Reset then idle: count = 0, empty = 1, full = 0, in_ready = 1, out_valid = 0, out_data = 0, skew_valid = 4'b0000.
- Push 4 rows 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D with out_ready = 0 -> full = 1, in_ready = 0, count = 4. A 5th push is ignored. Pop 4 -> same order out; empty = 1.
- Pop of row 0x44332211 at edge T -> skew_valid[0] = 1 with lane 0 = 0x11 after T; lanes 1/2/3 = 0x22/0x33/0x44 after T+1/T+2/T+3. Each lane valid for exactly one cycle.
- Preload 2 rows, then 6 cycles with recirc = 1 and out_ready = 1 -> out_data alternates row0, row1, row0, ...; count stays 2; in_ready = 0 throughout.
- count = 2 with push and pop every cycle for 10 cycles -> count stays 2, data order preserved across pointer wrap.
- Mid-stream, clear asserted with in_valid = out_ready = 1 -> next cycle count = 0, empty = 1, skew_valid = 0. Async reset pulse mid-skew -> all outputs zero immediately, before the next clk edge.
